// File: rtl/audio_stream_pkg.sv
// audio_stream_pkg
//   Shared definitions for the audio stream sequencer:
//     - state_e          : sequencer state encoding
//     - HDR_MAGIC_DEFAULT: default first header byte
//     - BD_*             : bit-depth codes (0=16, 1=24, 2=32, 3=DoP)
//     - CFG_*            : bit positions inside the CFG header byte
//     - bytes_per_frame(): stereo frame size in bytes for a bit-depth code
//     - len_frame_ok()   : LEN is a whole number of frames (no divider)
package audio_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_CFG = 3'd1,
        ST_HDR_LEN = 3'd2,
        ST_CHECK   = 3'd3,
        ST_STREAM  = 3'd4,
        ST_SKIP    = 3'd5,
        ST_DRAIN   = 3'd6
    } state_e;

    localparam logic [7:0] HDR_MAGIC_DEFAULT = 8'hA5;

    localparam logic [1:0] BD_16  = 2'd0;
    localparam logic [1:0] BD_24  = 2'd1;
    localparam logic [1:0] BD_32  = 2'd2;
    localparam logic [1:0] BD_DOP = 2'd3;

    localparam int CFG_RSV_HI = 7;
    localparam int CFG_RSV_LO = 6;
    localparam int CFG_SR_HI  = 5;
    localparam int CFG_SR_LO  = 3;
    localparam int CFG_BD_HI  = 2;
    localparam int CFG_BD_LO  = 1;
    localparam int CFG_CH     = 0;

    function automatic logic [3:0] bytes_per_frame(input logic [1:0] bd);
        logic [3:0] f;
        case (bd)
            BD_16:   f = 4'd4;
            BD_24:   f = 4'd6;
            BD_32:   f = 4'd8;
            default: f = 4'd6;   // DoP carries 24-bit containers
        endcase
        return f;
    endfunction

    // Frame sizes 4 and 8 are powers of two; 6 needs "even and divisible
    // by 3". Since 4 == 1 (mod 3), the sum of the base-4 digits keeps the
    // residue; two folds bring it into 0..9 where a constant compare works.
    function automatic logic len_frame_ok(input logic [31:0] len, input logic [1:0] bd);
        logic [5:0] s1;
        logic [3:0] s2;
        logic       div3;
        logic       ok;
        s1 = '0;
        for (int i = 0; i < 16; i++) begin
            s1 = s1 + {4'd0, len[2*i +: 2]};
        end
        s2   = {2'b00, s1[5:4]} + {2'b00, s1[3:2]} + {2'b00, s1[1:0]};
        div3 = (s2 == 4'd0) || (s2 == 4'd3) || (s2 == 4'd6) || (s2 == 4'd9);
        case (bytes_per_frame(bd))
            4'd4:    ok = (len[1:0] == 2'b00);
            4'd8:    ok = (len[2:0] == 3'b000);
            default: ok = (len[0] == 1'b0) && div3;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/audio_stream_ctrl_sync.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level.
//   Ports: clk_i (destination clock), reset_n_i (async active-low reset),
//          d_i (asynchronous input), q_o (synchronized output).
module sync_2ff (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl
//   Parses a 6-byte header (MAGIC, CFG, LEN[31:0] MSB first) from the host
//   byte stream, validates it, forwards exactly LEN payload bytes into the
//   transmitter FIFO, then holds the configuration until the transmitter
//   has started and stopped streaming.
//
//   Host input handshake: a byte moves when in_valid_i & in_ready_o are both
//   high at a rising clk_i edge; in_data_i must be stable while in_valid_i is
//   high; in_ready_o never depends on in_valid_i.
//
//   Ports:
//     clk_i, reset_n_i         clock, async active-low reset
//     in_valid_i/in_data_i/in_ready_o   host byte stream
//     fifo_wr_en_o/fifo_wr_data_o       FIFO write port (1 cycle after accept)
//     fifo_afull_i/fifo_full_i          FIFO back-pressure
//     streaming_i              transmitter streaming flag (asynchronous)
//     sample_rate_o/bit_depth_o/channels_o  latched configuration
//     busy_o, hdr_err_o        status
//     stream_cnt_o, err_cnt_o  saturating counters (AUDIO_STREAM_CTRL_STATS_EN)
//     dbg_state_o              current sequencer state
//
//   Build option: AUDIO_STREAM_CTRL_STATS_EN enables the two counters;
//   without it both counter outputs are tied to zero.
module audio_stream_ctrl
    import audio_stream_pkg::*;
#(
    parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DEFAULT,
    parameter int          LEN_W     = 32
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        fifo_wr_en_o,
    output logic [7:0]  fifo_wr_data_o,
    input  logic        fifo_afull_i,
    input  logic        fifo_full_i,
    input  logic        streaming_i,
    output logic [2:0]  sample_rate_o,
    output logic [1:0]  bit_depth_o,
    output logic        channels_o,
    output logic        busy_o,
    output logic        hdr_err_o,
    output logic [15:0] stream_cnt_o,
    output logic [15:0] err_cnt_o,
    output logic [2:0]  dbg_state_o
);

    state_e           state_q, state_d;
    logic [7:0]       cfg_q, cfg_d;
    logic [31:0]      len_q, len_d;
    logic [1:0]       idx_q, idx_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [2:0]       sr_q, sr_d;
    logic [1:0]       bd_q, bd_d;
    logic             ch_q, ch_d;
    logic             err_q, err_d;
    logic             seen_q, seen_d;
    logic             rdy_en_q;
    logic             in_ready;
    logic             accept;
    logic             streaming_sync;
    logic             rsv_ok;
    logic             hdr_ok;

    sync_2ff u_sync_streaming (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .d_i      (streaming_i),
        .q_o      (streaming_sync)
    );

    assign rsv_ok = (cfg_q[CFG_RSV_HI:CFG_RSV_LO] == 2'b00);
    assign hdr_ok = rsv_ok && (len_q != 32'd0) &&
                    len_frame_ok(len_q, cfg_q[CFG_BD_HI:CFG_BD_LO]);

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE, ST_HDR_CFG, ST_HDR_LEN, ST_SKIP: in_ready = 1'b1;
            ST_STREAM: in_ready = ~fifo_afull_i & ~fifo_full_i;
            default:   in_ready = 1'b0;
        endcase
    end

    // rdy_en_q holds ready low during reset and until the first clock edge
    // after release.
    assign in_ready_o = in_ready & rdy_en_q;
    assign accept     = in_valid_i & in_ready_o;

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        sr_d      = sr_q;
        bd_d      = bd_q;
        ch_d      = ch_q;
        err_d     = 1'b0;
        seen_d    = seen_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (in_data_i == HDR_MAGIC)) state_d = ST_HDR_CFG;
            end
            ST_HDR_CFG: begin
                if (accept) begin
                    cfg_d   = in_data_i;
                    idx_d   = 2'd0;
                    state_d = ST_HDR_LEN;
                end
            end
            ST_HDR_LEN: begin
                if (accept) begin
                    len_d = {len_q[23:0], in_data_i};
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                rem_d = LEN_W'(len_q);
                if (hdr_ok) begin
                    sr_d    = cfg_q[CFG_SR_HI:CFG_SR_LO];
                    bd_d    = cfg_q[CFG_BD_HI:CFG_BD_LO];
                    ch_d    = cfg_q[CFG_CH];
                    state_d = ST_STREAM;
                end else begin
                    err_d = 1'b1;
                    // Bad reserved bits mean the header itself is untrusted,
                    // and a zero length has nothing to skip.
                    if (!rsv_ok || (len_q == 32'd0)) begin
                        rem_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = in_data_i;
                    rem_d     = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        seen_d  = 1'b0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_SKIP: begin
                if (accept) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Exit only after a full high-then-low cycle of the flag.
                if (streaming_sync) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    seen_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rem_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            sr_q      <= '0;
            bd_q      <= '0;
            ch_q      <= 1'b0;
            err_q     <= 1'b0;
            seen_q    <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            sr_q      <= sr_d;
            bd_q      <= bd_d;
            ch_q      <= ch_d;
            err_q     <= err_d;
            seen_q    <= seen_d;
            rdy_en_q  <= 1'b1;
        end
    end

    assign fifo_wr_en_o   = wr_en_q;
    assign fifo_wr_data_o = wr_data_q;
    assign sample_rate_o  = sr_q;
    assign bit_depth_o    = bd_q;
    assign channels_o     = ch_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign hdr_err_o      = err_q;
    assign dbg_state_o    = state_q;

`ifdef AUDIO_STREAM_CTRL_STATS_EN
    logic [15:0] stream_cnt_q;
    logic [15:0] err_cnt_q;
    logic        stream_done;

    assign stream_done = (state_q == ST_DRAIN) && (state_d == ST_IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stream_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            if (stream_done && (stream_cnt_q != 16'hFFFF)) stream_cnt_q <= stream_cnt_q + 16'd1;
            if (err_q && (err_cnt_q != 16'hFFFF))          err_cnt_q    <= err_cnt_q + 16'd1;
        end
    end

    assign stream_cnt_o = stream_cnt_q;
    assign err_cnt_o    = err_cnt_q;
`else
    assign stream_cnt_o = 16'd0;
    assign err_cnt_o    = 16'd0;
`endif

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// tb_audio_stream_ctrl
//   Self-checking bench for audio_stream_ctrl. Headers are judged by a
//   transaction-level model (plain modulo arithmetic on the frame size);
//   accepted payloads are queued in exp_q and matched against FIFO writes.
module tb_audio_stream_ctrl;

`ifdef AUDIO_STREAM_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk_i        = 1'b0;
    logic        reset_n_i    = 1'b0;
    logic        in_valid_i   = 1'b0;
    logic [7:0]  in_data_i    = 8'h00;
    logic        fifo_afull_i = 1'b0;
    logic        fifo_full_i  = 1'b0;
    logic        streaming_i  = 1'b0;
    logic        in_ready_o;
    logic        fifo_wr_en_o;
    logic [7:0]  fifo_wr_data_o;
    logic [2:0]  sample_rate_o;
    logic [1:0]  bit_depth_o;
    logic        channels_o;
    logic        busy_o;
    logic        hdr_err_o;
    logic [15:0] stream_cnt_o;
    logic [15:0] err_cnt_o;
    logic [2:0]  dbg_state_o;

    always #5 clk_i = ~clk_i;

    audio_stream_ctrl dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .in_valid_i    (in_valid_i),
        .in_data_i     (in_data_i),
        .in_ready_o    (in_ready_o),
        .fifo_wr_en_o  (fifo_wr_en_o),
        .fifo_wr_data_o(fifo_wr_data_o),
        .fifo_afull_i  (fifo_afull_i),
        .fifo_full_i   (fifo_full_i),
        .streaming_i   (streaming_i),
        .sample_rate_o (sample_rate_o),
        .bit_depth_o   (bit_depth_o),
        .channels_o    (channels_o),
        .busy_o        (busy_o),
        .hdr_err_o     (hdr_err_o),
        .stream_cnt_o  (stream_cnt_o),
        .err_cnt_o     (err_cnt_o),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks   = 0;
    int         n_fail     = 0;
    logic [7:0] exp_q[$];
    int         err_seen   = 0;
    int         errs_exp   = 0;
    int         errs_rst   = 0;
    int         streams_rst = 0;
    logic [2:0] sr_exp     = 3'd0;
    logic [1:0] bd_exp     = 2'd0;
    logic       ch_exp     = 1'b0;
    bit         afull_rand = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: frame = 2 x bytes per sample (2/3/4/3 for depth 0/1/2/3).
    function automatic bit hdr_valid(input logic [7:0] cfg, input logic [31:0] len);
        longint f;
        case (cfg[2:1])
            2'd0:    f = 4;
            2'd1:    f = 6;
            2'd2:    f = 8;
            default: f = 6;
        endcase
        return (cfg[7:6] == 2'b00) && (len != 0) && ((longint'(len) % f) == 0);
    endfunction

    function automatic int frame_of(input logic [7:0] cfg);
        return (cfg[2:1] == 2'd0) ? 4 : (cfg[2:1] == 2'd2) ? 8 : 6;
    endfunction

    always @(negedge clk_i) begin
        if (fifo_wr_en_o) begin
            if (exp_q.size() == 0) check_eq("spurious_write", fifo_wr_en_o, 0);
            else                   check_eq("fifo_data", fifo_wr_data_o, exp_q.pop_front());
        end
        if (hdr_err_o) err_seen++;
    end

    always @(negedge clk_i) begin
        if (afull_rand) fifo_afull_i = ($urandom_range(0, 3) == 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic send_byte(input logic [7:0] b);
        int   waited;
        logic acc;
        waited     = 0;
        in_valid_i = 1'b1;
        in_data_i  = b;
        forever begin
            #1;
            acc = in_ready_o;
            @(negedge clk_i);
            if (acc) break;
            waited++;
            if (waited > 200) begin
                check_eq("in_ready_timeout", in_ready_o, 1);
                break;
            end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] cfg, input logic [31:0] len);
        send_byte(8'hA5);
        send_byte(cfg);
        for (int i = 3; i >= 0; i--) send_byte(len[8*i +: 8]);
    endtask

    task automatic set_cfg_exp(input logic [7:0] cfg);
        sr_exp = cfg[5:3];
        bd_exp = cfg[2:1];
        ch_exp = cfg[0];
    endtask

    task automatic check_cfg(input string tag);
        check_eq({tag, "_rate"}, sample_rate_o, sr_exp);
        check_eq({tag, "_depth"}, bit_depth_o, bd_exp);
        check_eq({tag, "_chan"}, channels_o, ch_exp);
    endtask

    task automatic apply_reset();
        in_valid_i  = 1'b0;
        streaming_i = 1'b0;
        fifo_afull_i = 1'b0;
        reset_n_i   = 1'b0;
        #1;
        check_eq("rst_ready", in_ready_o, 0);
        check_eq("rst_wr_en", fifo_wr_en_o, 0);
        check_eq("rst_wr_data", fifo_wr_data_o, 0);
        check_eq("rst_rate", sample_rate_o, 0);
        check_eq("rst_depth", bit_depth_o, 0);
        check_eq("rst_chan", channels_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_err", hdr_err_o, 0);
        check_eq("rst_stream_cnt", stream_cnt_o, 0);
        check_eq("rst_err_cnt", err_cnt_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        exp_q.delete();
        set_cfg_exp(8'h00);
        errs_rst    = 0;
        streams_rst = 0;
        #1;
        check_eq("ready_before_first_edge", in_ready_o, 0);
        @(negedge clk_i);
        check_eq("ready_after_first_edge", in_ready_o, 1);
    endtask

    task automatic do_drain();
        int w;
        repeat (4) @(negedge clk_i);
        check_eq("drain_busy_hold", busy_o, 1);
        check_eq("drain_ready_low", in_ready_o, 0);
        streaming_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_eq("drain_busy_while_streaming", busy_o, 1);
        streaming_i = 1'b0;
        w = 0;
        while (busy_o && (w < 20)) begin
            @(negedge clk_i);
            w++;
        end
        check_eq("drain_exit", busy_o, 0);
        streams_rst++;
        check_eq("stream_cnt", stream_cnt_o, STATS ? streams_rst : 0);
        check_eq("no_err_on_valid", err_seen, errs_exp);
    endtask

    task automatic run_txn(input logic [7:0] cfg, input logic [31:0] len, input int n_junk);
        logic [7:0] b;
        bit         ok;
        for (int j = 0; j < n_junk; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            send_byte(b);
        end
        ok = hdr_valid(cfg, len);
        send_header(cfg, len);
        #1;
        check_eq("check_cycle_ready", in_ready_o, 0);
        @(negedge clk_i);
        if (ok) begin
            set_cfg_exp(cfg);
            check_cfg("cfg_latched");
            check_eq("stream_busy", busy_o, 1);
            #1;
            check_eq("stream_ready", in_ready_o, !fifo_afull_i);
            for (int i = 0; i < int'(len); i++) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                send_byte(b);
                if (i == 0) check_eq("wr_en_latency", fifo_wr_en_o, 1);
            end
            do_drain();
        end else begin
            errs_exp++;
            errs_rst++;
            if (cfg[7:6] == 2'b00) begin
                for (int i = 0; i < int'(len); i++) send_byte(8'($urandom_range(0, 255)));
            end
            @(negedge clk_i);
            check_eq("hdr_err_pulses", err_seen, errs_exp);
            check_eq("reject_idle", busy_o, 0);
            check_eq("err_cnt", err_cnt_o, STATS ? errs_rst : 0);
            check_cfg("cfg_unchanged");
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0]  cfg;
        logic [31:0] len;
        logic [7:0]  b;
        int          r;
        int          f;

        @(negedge clk_i);
        apply_reset();

        // rejected: 24-bit stereo (F=6), LEN 8; payload skipped
        run_txn(8'h03, 32'd8, 0);
        // accepted: 16-bit stereo (F=4), LEN 8
        run_txn(8'h01, 32'd8, 0);
        // junk before a header, then 32-bit stereo (F=8), LEN 8
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        run_txn(8'h05, 32'd8, 0);
        // reserved bits set
        run_txn(8'hC4, 32'd8, 0);
        // LEN below one frame, and LEN zero
        run_txn(8'h02, 32'd5, 0);
        run_txn(8'h00, 32'd3, 0);
        run_txn(8'h01, 32'd0, 0);

        // almost-full held for 10 cycles mid-payload
        send_header(8'h09, 32'd12);
        @(negedge clk_i);
        set_cfg_exp(8'h09);
        check_cfg("afull_cfg");
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_byte(b);
        end
        b = 8'($urandom_range(0, 255));
        fifo_afull_i = 1'b1;
        in_valid_i   = 1'b1;
        in_data_i    = b;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("afull_ready_low", in_ready_o, 0);
            if (i > 0) check_eq("afull_no_write", fifo_wr_en_o, 0);
            @(negedge clk_i);
        end
        fifo_afull_i = 1'b0;
        exp_q.push_back(b);
        send_byte(b);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_byte(b);
        end
        do_drain();

        // reset after 3 of 12 payload bytes
        send_header(8'h01, 32'd12);
        @(negedge clk_i);
        set_cfg_exp(8'h01);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_byte(b);
        end
        @(negedge clk_i);
        check_eq("writes_before_reset", exp_q.size(), 0);
        apply_reset();
        run_txn(8'h01, 32'd4, 0);

        // LEN = 0xFFFF_FFFF is never a whole number of frames
        send_header(8'h01, 32'hFFFF_FFFF);
        @(negedge clk_i);
        errs_exp++;
        errs_rst++;
        @(negedge clk_i);
        check_eq("max_len_err", err_seen, errs_exp);
        check_eq("max_len_skip_busy", busy_o, 1);
        check_eq("max_len_skip_ready", in_ready_o, 1);
        check_eq("max_len_err_cnt", err_cnt_o, STATS ? errs_rst : 0);
        apply_reset();

        // randomized headers with random almost-full back-pressure
        afull_rand = 1'b1;
        for (int t = 0; t < 25; t++) begin
            r   = $urandom_range(0, 9);
            cfg = {2'b00, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
            f   = frame_of(cfg);
            if (r == 0) cfg[7:6] = 2'($urandom_range(1, 3));
            if (r <= 6)      len = 32'(f * $urandom_range(1, 6));
            else if (r == 7) len = 32'($urandom_range(1, f - 1));
            else if (r == 8) len = 32'(f * $urandom_range(1, 4) + $urandom_range(1, f - 1));
            else             len = 32'd0;
            run_txn(cfg, len, $urandom_range(0, 2));
        end
        afull_rand = 1'b0;
        @(negedge clk_i);
        fifo_afull_i = 1'b0;

        repeat (3) @(negedge clk_i);
        check_eq("all_writes_seen", exp_q.size(), 0);
        check_eq("total_hdr_err", err_seen, errs_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
